// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared encodings for the execute stage.
//   ALUOp class encodings driven by the decoder,
//   the internal 4-bit ALU operation enum,
//   and the {funct7[5], funct3} patterns decoded for R-type ops.
package ex_stage_pkg;

    // ALU operation class from the decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads/stores
    localparam logic [1:0] ALUOP_SUB   = 2'b01;  // BEQ compare
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode Funct
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;  // treated as ADD

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_op_e;

    // Funct = {funct7[5], funct3}
    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b1000;
    localparam logic [3:0] FN_AND = 4'b0111;
    localparam logic [3:0] FN_OR  = 4'b0110;
    localparam logic [3:0] FN_XOR = 4'b0100;
    localparam logic [3:0] FN_SLL = 4'b0001;
    localparam logic [3:0] FN_SRL = 4'b0101;
    localparam logic [3:0] FN_SRA = 4'b1101;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, forwarding sources, pipeline control and the
// registered EX/MEM outputs of the execute stage.
//   master: the side producing stage inputs and consuming EX/MEM fields
//   slave : the execute stage itself
interface ex_stage_if #(parameter int XLEN = 64);
    // ID/EX register contents
    logic [XLEN-1:0] PC_in, data1_in, data2_in, immData_in;
    logic [4:0]      rs1_in, rs2_in, rd_in;
    logic [3:0]      Funct_in;
    logic            Branch_in, MemRead_in, MemtoReg_in, MemWrite_in;
    logic            ALUSrc_in, RegWrite_in;
    logic [1:0]      ALUOp_in;
    // forwarding sources
    logic            mem_RegWrite, wb_RegWrite;
    logic [4:0]      mem_rd, wb_rd;
    logic [XLEN-1:0] mem_result, wb_data;
    // pipeline control
    logic            stall, flush;
    // EX/MEM register
    logic [XLEN-1:0] ALUResult_out, WriteData_out, BranchTarget_out;
    logic [4:0]      rd_out;
    logic            Zero_out, BranchTaken_out, MemRead_out, MemtoReg_out;
    logic            MemWrite_out, RegWrite_out;

    modport master (
        output PC_in, data1_in, data2_in, immData_in, rs1_in, rs2_in, rd_in,
               Funct_in, Branch_in, MemRead_in, MemtoReg_in, MemWrite_in,
               ALUSrc_in, RegWrite_in, ALUOp_in, mem_RegWrite, wb_RegWrite,
               mem_rd, wb_rd, mem_result, wb_data, stall, flush,
        input  ALUResult_out, WriteData_out, BranchTarget_out, rd_out,
               Zero_out, BranchTaken_out, MemRead_out, MemtoReg_out,
               MemWrite_out, RegWrite_out
    );

    modport slave (
        input  PC_in, data1_in, data2_in, immData_in, rs1_in, rs2_in, rd_in,
               Funct_in, Branch_in, MemRead_in, MemtoReg_in, MemWrite_in,
               ALUSrc_in, RegWrite_in, ALUOp_in, mem_RegWrite, wb_RegWrite,
               mem_rd, wb_rd, mem_result, wb_data, stall, flush,
        output ALUResult_out, WriteData_out, BranchTarget_out, rd_out,
               Zero_out, BranchTaken_out, MemRead_out, MemtoReg_out,
               MemWrite_out, RegWrite_out
    );
endinterface

// File: rtl/ex_stage_alu.sv
// alu: combinational XLEN-bit ALU.
//   a, b   : operands
//   op     : operation (alu_op_e)
//   result : a op b, modulo 2^XLEN; shifts use b[5:0]
//   zero   : result == 0
module alu
    import ex_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    logic [5:0] shamt;

    assign shamt = b[5:0];

    always_comb begin
        result = a + b;
        case (op)
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            ALU_SRA: result = $unsigned($signed(a) >>> shamt);
            default: result = a + b;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with MEM/WB forwarding, ALU control and the
// EX/MEM pipeline register.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every EX/MEM field
//   bus   : ex_stage_if.slave -- ID/EX inputs, forwarding sources,
//           stall/flush and the registered EX/MEM outputs
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic       clk,
    input  logic       reset,
    ex_stage_if.slave  bus
);
    logic [XLEN-1:0] fwd_a, fwd_b, opnd_b, alu_res, br_tgt;
    logic            alu_zero;
    alu_op_e         op;

    // MEM result is younger than WB data, so it wins when both match.
    // x0 is never forwarded since it is hard-wired to zero.
    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_val
    );
        if (bus.mem_RegWrite && bus.mem_rd != 5'd0 && bus.mem_rd == rs)
            return bus.mem_result;
        else if (bus.wb_RegWrite && bus.wb_rd != 5'd0 && bus.wb_rd == rs)
            return bus.wb_data;
        else
            return rf_val;
    endfunction

    assign fwd_a  = fwd(bus.rs1_in, bus.data1_in);
    assign fwd_b  = fwd(bus.rs2_in, bus.data2_in);
    assign opnd_b = bus.ALUSrc_in ? bus.immData_in : fwd_b;
    assign br_tgt = bus.PC_in + (bus.immData_in << 1);

    // ALU control
    always_comb begin
        op = ALU_ADD;
        case (bus.ALUOp_in)
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_RTYPE: begin
                case (bus.Funct_in)
                    FN_SUB:  op = ALU_SUB;
                    FN_AND:  op = ALU_AND;
                    FN_OR:   op = ALU_OR;
                    FN_XOR:  op = ALU_XOR;
                    FN_SLL:  op = ALU_SLL;
                    FN_SRL:  op = ALU_SRL;
                    FN_SRA:  op = ALU_SRA;
                    default: op = ALU_ADD;
                endcase
            end
            default: op = ALU_ADD;
        endcase
    end

    alu #(.XLEN(XLEN)) u_alu (
        .a      (fwd_a),
        .b      (opnd_b),
        .op     (op),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // EX/MEM register. Flush overrides stall: it loads a bubble (controls
    // cleared); data fields are captured anyway since nobody consumes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ALUResult_out    <= '0;
            bus.WriteData_out    <= '0;
            bus.BranchTarget_out <= '0;
            bus.rd_out           <= '0;
            bus.Zero_out         <= 1'b0;
            bus.BranchTaken_out  <= 1'b0;
            bus.MemRead_out      <= 1'b0;
            bus.MemtoReg_out     <= 1'b0;
            bus.MemWrite_out     <= 1'b0;
            bus.RegWrite_out     <= 1'b0;
        end else if (bus.flush || !bus.stall) begin
            bus.ALUResult_out    <= alu_res;
            bus.WriteData_out    <= fwd_b;
            bus.BranchTarget_out <= br_tgt;
            bus.rd_out           <= bus.rd_in;
            bus.Zero_out         <= alu_zero;
            bus.BranchTaken_out  <= !bus.flush && bus.Branch_in && alu_zero;
            bus.MemRead_out      <= !bus.flush && bus.MemRead_in;
            bus.MemtoReg_out     <= !bus.flush && bus.MemtoReg_in;
            bus.MemWrite_out     <= !bus.flush && bus.MemWrite_in;
            bus.RegWrite_out     <= !bus.flush && bus.RegWrite_in;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage. Each cycle the bench computes
// the expected EX/MEM contents from its own reference model, queues them,
// and compares after the clock edge.
module tb_ex_stage;
    localparam int XLEN = 64;

    logic clk, reset;

    ex_stage_if #(.XLEN(XLEN)) bus ();

    ex_stage #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] alu, wd, bt;
        logic [4:0]  rd;
        logic        zero, btk, mr, m2r, mw, rw;
        logic        dv;  // data fields meaningful (not after flush)
    } exp_t;

    exp_t  sb[$];
    exp_t  last;
    int    n_chk  = 0;
    int    n_pass = 0;
    string tname  = "init";

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s.%s: got %h expected %h", tname, tag, got, exp);
    endtask

    // Reference model of the stage's combinational function
    function automatic exp_t model();
        logic [63:0] a, b2, b, r;
        exp_t e;
        if (bus.mem_RegWrite && bus.mem_rd != 0 && bus.mem_rd == bus.rs1_in) a = bus.mem_result;
        else if (bus.wb_RegWrite && bus.wb_rd != 0 && bus.wb_rd == bus.rs1_in) a = bus.wb_data;
        else a = bus.data1_in;
        if (bus.mem_RegWrite && bus.mem_rd != 0 && bus.mem_rd == bus.rs2_in) b2 = bus.mem_result;
        else if (bus.wb_RegWrite && bus.wb_rd != 0 && bus.wb_rd == bus.rs2_in) b2 = bus.wb_data;
        else b2 = bus.data2_in;
        b = bus.ALUSrc_in ? bus.immData_in : b2;
        case (bus.ALUOp_in)
            2'b01: r = a - b;
            2'b10: case (bus.Funct_in)
                4'b1000: r = a - b;
                4'b0111: r = a & b;
                4'b0110: r = a | b;
                4'b0100: r = a ^ b;
                4'b0001: r = a << b[5:0];
                4'b0101: r = a >> b[5:0];
                4'b1101: r = $unsigned($signed(a) >>> b[5:0]);
                default: r = a + b;
            endcase
            default: r = a + b;
        endcase
        e.alu  = r;
        e.wd   = b2;
        e.bt   = bus.PC_in + {bus.immData_in[62:0], 1'b0};
        e.rd   = bus.rd_in;
        e.zero = (r == 64'd0);
        e.btk  = bus.Branch_in && (r == 64'd0);
        e.mr   = bus.MemRead_in;
        e.m2r  = bus.MemtoReg_in;
        e.mw   = bus.MemWrite_in;
        e.rw   = bus.RegWrite_in;
        e.dv   = 1'b1;
        return e;
    endfunction

    task automatic cmp_out(input exp_t e);
        if (e.dv) begin
            chk("alu",   bus.ALUResult_out,    e.alu);
            chk("wdata", bus.WriteData_out,    e.wd);
            chk("btgt",  bus.BranchTarget_out, e.bt);
            chk("rd",    {59'd0, bus.rd_out},  {59'd0, e.rd});
            chk("zero",  {63'd0, bus.Zero_out}, {63'd0, e.zero});
        end
        chk("btaken", {63'd0, bus.BranchTaken_out}, {63'd0, e.btk});
        chk("mread",  {63'd0, bus.MemRead_out},     {63'd0, e.mr});
        chk("m2reg",  {63'd0, bus.MemtoReg_out},    {63'd0, e.m2r});
        chk("mwrite", {63'd0, bus.MemWrite_out},    {63'd0, e.mw});
        chk("rwrite", {63'd0, bus.RegWrite_out},    {63'd0, e.rw});
    endtask

    task automatic zero_chk();
        exp_t z;
        z = '0;
        z.dv = 1'b1;
        cmp_out(z);
    endtask

    // One clock: queue expectation, clock, pop and compare.
    task automatic cycle(input bit stl, input bit fl);
        exp_t nx;
        bus.stall = stl;
        bus.flush = fl;
        if (fl) begin
            nx = model();
            {nx.btk, nx.mr, nx.m2r, nx.mw, nx.rw, nx.dv} = '0;
        end else if (stl) nx = last;
        else nx = model();
        sb.push_back(nx);
        last = nx;
        @(posedge clk);
        #1;
        if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
        else cmp_out(sb.pop_front());
    endtask

    task automatic clr_in();
        bus.PC_in = '0; bus.data1_in = '0; bus.data2_in = '0; bus.immData_in = '0;
        bus.rs1_in = '0; bus.rs2_in = '0; bus.rd_in = '0; bus.Funct_in = '0;
        bus.Branch_in = 0; bus.MemRead_in = 0; bus.MemtoReg_in = 0; bus.MemWrite_in = 0;
        bus.ALUSrc_in = 0; bus.RegWrite_in = 0; bus.ALUOp_in = '0;
        bus.mem_RegWrite = 0; bus.wb_RegWrite = 0; bus.mem_rd = '0; bus.wb_rd = '0;
        bus.mem_result = '0; bus.wb_data = '0; bus.stall = 0; bus.flush = 0;
    endtask

    initial begin
        reset = 1'b1;
        clr_in();
        last = '0;
        last.dv = 1'b1;
        #2;
        tname = "reset";
        zero_chk();
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;

        // R-type SUB wraps to -2
        tname = "sub";
        clr_in();
        bus.ALUOp_in = 2'b10; bus.Funct_in = 4'b1000;
        bus.data1_in = 64'd5; bus.data2_in = 64'd7; bus.rd_in = 5'd4; bus.RegWrite_in = 1;
        cycle(0, 0);
        chk("alu_const",  bus.ALUResult_out, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("zero_const", {63'd0, bus.Zero_out}, 64'd0);

        // forwarding priority: MEM over WB, then WB when MEM targets x0
        tname = "fwd_mem";
        clr_in();
        bus.rs1_in = 5'd3; bus.mem_rd = 5'd3; bus.wb_rd = 5'd3;
        bus.mem_RegWrite = 1; bus.wb_RegWrite = 1;
        bus.mem_result = 64'd10; bus.wb_data = 64'd20; bus.data2_in = 64'd1;
        cycle(0, 0);
        chk("alu_const", bus.ALUResult_out, 64'd11);
        tname = "fwd_wb";
        bus.mem_rd = 5'd0;
        cycle(0, 0);
        chk("alu_const", bus.ALUResult_out, 64'd21);

        // taken BEQ
        tname = "beq";
        clr_in();
        bus.Branch_in = 1; bus.ALUOp_in = 2'b01;
        bus.data1_in = 64'd9; bus.data2_in = 64'd9;
        bus.PC_in = 64'h100; bus.immData_in = 64'd8;
        cycle(0, 0);
        chk("btk_const",  {63'd0, bus.BranchTaken_out}, 64'd1);
        chk("zero_const", {63'd0, bus.Zero_out}, 64'd1);
        chk("btgt_const", bus.BranchTarget_out, 64'h110);

        // SRA sign-fill with immediate shift amount
        tname = "sra";
        clr_in();
        bus.ALUOp_in = 2'b10; bus.Funct_in = 4'b1101;
        bus.data1_in = 64'h8000_0000_0000_0000; bus.ALUSrc_in = 1; bus.immData_in = 64'd4;
        cycle(0, 0);
        chk("alu_const", bus.ALUResult_out, 64'hF800_0000_0000_0000);

        // stall + flush: flush wins and clears controls
        tname = "load_ctl";
        clr_in();
        bus.RegWrite_in = 1; bus.MemWrite_in = 1; bus.data1_in = 64'd3; bus.rd_in = 5'd7;
        cycle(0, 0);
        tname = "stall_flush";
        cycle(1, 1);
        chk("rw_const", {63'd0, bus.RegWrite_out}, 64'd0);
        chk("mw_const", {63'd0, bus.MemWrite_out}, 64'd0);

        // stall alone holds for three cycles while inputs change
        tname = "pre_stall";
        bus.ALUOp_in = 2'b10; bus.Funct_in = 4'b0110;
        bus.data1_in = 64'hF0; bus.data2_in = 64'h0F; bus.MemRead_in = 1; bus.MemtoReg_in = 1;
        cycle(0, 0);
        tname = "stall";
        for (int i = 0; i < 3; i++) begin
            bus.data1_in = 64'(i + 100); bus.rd_in = 5'(i + 1); bus.RegWrite_in = ~bus.RegWrite_in;
            cycle(1, 0);
            chk("alu_const", bus.ALUResult_out, 64'hFF);
        end

        // random traffic with occasional stall/flush
        tname = "rand";
        for (int i = 0; i < 60; i++) begin
            bus.PC_in = {$urandom, $urandom}; bus.data1_in = {$urandom, $urandom};
            bus.data2_in = (i % 4 == 0) ? bus.data1_in : {$urandom, $urandom};
            bus.immData_in = {32'd0, 26'd0, 6'($urandom)};
            bus.rs1_in = 5'($urandom_range(0, 3)); bus.rs2_in = 5'($urandom_range(0, 3));
            bus.rd_in = 5'($urandom); bus.Funct_in = 4'($urandom); bus.ALUOp_in = 2'($urandom);
            {bus.Branch_in, bus.MemRead_in, bus.MemtoReg_in, bus.MemWrite_in,
             bus.ALUSrc_in, bus.RegWrite_in} = 6'($urandom);
            bus.mem_RegWrite = 1'($urandom); bus.wb_RegWrite = 1'($urandom);
            bus.mem_rd = 5'($urandom_range(0, 3)); bus.wb_rd = 5'($urandom_range(0, 3));
            bus.mem_result = {$urandom, $urandom}; bus.wb_data = {$urandom, $urandom};
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        // reset mid-run, mid-stall: outputs clear before the next edge
        tname = "pre_rst";
        clr_in();
        bus.data1_in = 64'd42; bus.RegWrite_in = 1; bus.MemRead_in = 1; bus.rd_in = 5'd9;
        bus.PC_in = 64'h40;
        cycle(0, 0);
        bus.stall = 1;
        #2;
        reset = 1'b1;
        #1;
        tname = "rst_async";
        zero_chk();
        @(posedge clk); #1;
        tname = "rst_hold";
        zero_chk();
        #2;
        reset = 1'b0;
        last = '0;
        last.dv = 1'b1;
        tname = "post_rst";
        bus.flush = 0;
        cycle(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
